// File: rtl/fifo_wr_arbiter_if.sv
// Handshake bundle between NUM_REQ producers, the write arbiter and one FIFO write port.
interface fifo_wr_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned ID_WIDTH = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          fifo_cs;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_data_in;
  logic                          grant_valid;
  logic [ID_WIDTH-1:0]           grant_id;

  // Producer/FIFO side.
  modport master (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_cs, fifo_wr_en, fifo_data_in, grant_valid, grant_id
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_cs, fifo_wr_en, fifo_data_in, grant_valid, grant_id
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-limited arbiter sharing one FIFO write port among NUM_REQ producers.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 4
) (
  input logic              clk,
  input logic              rst,
  fifo_wr_arbiter_if.slave bus
);
  localparam int unsigned ID_WIDTH  = $clog2(NUM_REQ);
  localparam int unsigned CNT_WIDTH = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StBurst = 1'b1;

  localparam logic [ID_WIDTH:0]    NumReqExt = (ID_WIDTH + 1)'(NUM_REQ);
  localparam logic [ID_WIDTH-1:0]  LastId    = ID_WIDTH'(NUM_REQ - 1);
  localparam logic [CNT_WIDTH-1:0] LastBeat  = CNT_WIDTH'(MAX_BURST - 1);

  logic [0:0]            state_q, state_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0]   grant_id_q, grant_id_d;
  logic [CNT_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;

  logic [DATA_WIDTH-1:0] slice [NUM_REQ];
  logic [ID_WIDTH:0]     idx_ext;
  logic [ID_WIDTH-1:0]   winner;
  logic                  any_valid;
  logic                  in_burst;
  logic                  granted_valid;
  logic                  beat;
  logic                  rel;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    assign slice[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    assign bus.req_ready[i] = in_burst & ~rst & ~bus.fifo_full & (grant_id_q == ID_WIDTH'(i));
  end

  // Scan starting at rr_ptr; one extra bit lets the index wrap without a modulo.
  always_comb begin
    idx_ext   = '0;
    winner    = '0;
    any_valid = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx_ext = {1'b0, rr_ptr_q} + (ID_WIDTH + 1)'(k);
      if (idx_ext >= NumReqExt) idx_ext = idx_ext - NumReqExt;
      if (!any_valid && bus.req_valid[idx_ext[ID_WIDTH-1:0]]) begin
        any_valid = 1'b1;
        winner    = idx_ext[ID_WIDTH-1:0];
      end
    end
  end

  assign in_burst         = (state_q == StBurst);
  assign granted_valid    = bus.req_valid[grant_id_q];
  assign beat             = in_burst & granted_valid & ~bus.fifo_full & ~rst;
  assign bus.fifo_wr_en   = beat;
  assign bus.fifo_cs      = beat;
  assign bus.fifo_data_in = in_burst ? slice[grant_id_q] : '0;
  assign bus.grant_valid  = in_burst;
  assign bus.grant_id     = grant_id_q;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    beat_cnt_d = beat_cnt_q;
    rel        = 1'b0;
    case (state_q)
      StIdle: begin
        if (any_valid) begin
          state_d    = StBurst;
          grant_id_d = winner;
          beat_cnt_d = '0;
        end
      end
      StBurst: begin
        if (beat) begin
          if (beat_cnt_q == LastBeat) rel = 1'b1;
          else beat_cnt_d = beat_cnt_q + 1'b1;
        end else if (!granted_valid) begin
          // A producer that goes idle gives up its grant even while the FIFO is full.
          rel = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (rel) begin
      state_d    = StIdle;
      beat_cnt_d = '0;
      rr_ptr_d   = (grant_id_q == LastId) ? '0 : grant_id_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: a 4-requester and a 3-requester instance.
module tb_fifo_wr_arbiter;
  typedef struct {
    int          id;
    logic [31:0] data;
    int          gap;   // cycles since previous write; -1 = not checked
  } exp_t;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   wr4;

  logic [31:0] pq4 [4][$];
  logic [31:0] pq3 [3][$];
  exp_t        sb4 [$];
  exp_t        sb3 [$];

  fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(32)) bus4 ();
  fifo_wr_arbiter_if #(.NUM_REQ(3), .DATA_WIDTH(32)) bus3 ();

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32), .MAX_BURST(4)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  fifo_wr_arbiter #(.NUM_REQ(3), .DATA_WIDTH(32), .MAX_BURST(4)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_cmp(input string tag, input exp_t e, input int id, input logic [31:0] d,
                        input int gap, input logic full, input logic cs);
    chk({tag, " grant_id"}, 64'(id), 64'(e.id));
    chk({tag, " data"}, 64'(d), 64'(e.data));
    chk({tag, " write while full"}, 64'(full), 64'd0);
    chk({tag, " cs follows wr_en"}, 64'(cs), 64'd1);
    if (e.gap >= 0) chk({tag, " write spacing"}, 64'(gap), 64'(e.gap));
  endtask

  task automatic exp4(input int id, input logic [31:0] d, input int gap);
    sb4.push_back('{id, d, gap});
  endtask

  task automatic exp3(input int id, input logic [31:0] d, input int gap);
    sb3.push_back('{id, d, gap});
  endtask

  task automatic wait_drain(input int sel);
    int n;
    n = 0;
    while (((sel == 4) ? sb4.size() : sb3.size()) > 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (((sel == 4) ? sb4.size() : sb3.size()) > 0) begin
      n_fail++;
      $display("FAIL drain dut%0d: %0d writes outstanding, expected 0", sel,
               (sel == 4) ? sb4.size() : sb3.size());
      if (sel == 4) sb4.delete();
      else sb3.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_writes(input int target);
    int n;
    n = 0;
    while (wr4 < target && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("write count wait", 64'(wr4 >= target), 64'd1);
  endtask

  // Producers: pop a word that fired on the last edge, then present the queue head.
  initial begin : drv4
    logic [3:0] fire;
    fire = '0;
    forever begin
      @(negedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (fire[i] && pq4[i].size() > 0) void'(pq4[i].pop_front());
        bus4.req_valid[i] = (pq4[i].size() > 0);
        bus4.req_data[i*32 +: 32] = (pq4[i].size() > 0) ? pq4[i][0] : 32'h0;
      end
      #2;
      fire = bus4.req_valid & bus4.req_ready;
    end
  end

  initial begin : drv3
    logic [2:0] fire;
    fire = '0;
    forever begin
      @(negedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (fire[i] && pq3[i].size() > 0) void'(pq3[i].pop_front());
        bus3.req_valid[i] = (pq3[i].size() > 0);
        bus3.req_data[i*32 +: 32] = (pq3[i].size() > 0) ? pq3[i][0] : 32'h0;
      end
      #2;
      fire = bus3.req_valid & bus3.req_ready;
    end
  end

  initial begin : mon4
    int   cyc;
    int   last;
    exp_t e;
    cyc  = 0;
    last = 0;
    forever begin
      @(negedge clk);
      cyc++;
      #3;
      if (bus4.fifo_wr_en === 1'b1) begin
        wr4++;
        if (sb4.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL dut4 write: got id %0d data %h, expected no write",
                   bus4.grant_id, bus4.fifo_data_in);
        end else begin
          e = sb4.pop_front();
          sb_cmp("dut4", e, int'(bus4.grant_id), bus4.fifo_data_in, cyc - last,
                 bus4.fifo_full, bus4.fifo_cs);
        end
        last = cyc;
      end
    end
  end

  initial begin : mon3
    int   cyc;
    int   last;
    exp_t e;
    cyc  = 0;
    last = 0;
    forever begin
      @(negedge clk);
      cyc++;
      #3;
      if (bus3.fifo_wr_en === 1'b1) begin
        if (sb3.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL dut3 write: got id %0d data %h, expected no write",
                   bus3.grant_id, bus3.fifo_data_in);
        end else begin
          e = sb3.pop_front();
          sb_cmp("dut3", e, int'(bus3.grant_id), bus3.fifo_data_in, cyc - last,
                 bus3.fifo_full, bus3.fifo_cs);
        end
        last = cyc;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running at time limit, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int base;
    n_tests = 0;
    n_fail  = 0;
    wr4     = 0;
    rst     = 1'b1;
    bus4.req_valid = '0;
    bus4.req_data  = '0;
    bus4.fifo_full = 1'b0;
    bus3.req_valid = '0;
    bus3.req_data  = '0;
    bus3.fifo_full = 1'b0;

    // Reset held with every requester valid.
    for (int i = 0; i < 4; i++) pq4[i].push_back(32'hF000_0000 + 32'(i));
    repeat (2) @(negedge clk);
    #2;
    chk("reset req_valid driven", 64'(bus4.req_valid), 64'hF);
    chk("reset grant_valid", 64'(bus4.grant_valid), 64'd0);
    chk("reset req_ready", 64'(bus4.req_ready), 64'd0);
    chk("reset fifo_wr_en", 64'(bus4.fifo_wr_en), 64'd0);
    chk("reset fifo_cs", 64'(bus4.fifo_cs), 64'd0);
    chk("reset fifo_data_in", 64'(bus4.fifo_data_in), 64'd0);
    chk("reset grant_id", 64'(bus4.grant_id), 64'd0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) pq4[i].delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    chk("idle grant_valid", 64'(bus4.grant_valid), 64'd0);

    // Single requester 1, three back-to-back words.
    @(negedge clk);
    pq4[1].push_back(32'h11);
    pq4[1].push_back(32'h22);
    pq4[1].push_back(32'h33);
    exp4(1, 32'h11, -1);
    exp4(1, 32'h22, 1);
    exp4(1, 32'h33, 1);
    #2;
    chk("single arbitration bubble", 64'(bus4.grant_valid), 64'd0);
    @(negedge clk);
    #2;
    chk("single grant_valid", 64'(bus4.grant_valid), 64'd1);
    chk("single grant_id", 64'(bus4.grant_id), 64'd1);
    chk("single req_ready", 64'(bus4.req_ready), 64'h2);
    chk("single fifo_wr_en", 64'(bus4.fifo_wr_en), 64'd1);
    wait_drain(4);
    chk("single released", 64'(bus4.grant_valid), 64'd0);

    // Fairness: all four valid, 8 words each.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 8; k++) pq4[i].push_back(32'h3000_0000 + 32'(i * 256 + k));
    for (int r = 0; r < 2; r++)
      for (int g = 0; g < 4; g++)
        for (int b = 0; b < 4; b++)
          exp4(g, 32'h3000_0000 + 32'(g * 256 + r * 4 + b),
               (r == 0 && g == 0 && b == 0) ? -1 : ((b == 0) ? 2 : 1));
    wait_drain(4);

    // Full stall after beat 2; fifth word needs a fresh grant after the burst limit.
    base = wr4;
    for (int k = 0; k < 5; k++) pq4[1].push_back(32'h4000_0000 + 32'(k));
    exp4(1, 32'h4000_0000, -1);
    exp4(1, 32'h4000_0001, 1);
    exp4(1, 32'h4000_0002, 4);
    exp4(1, 32'h4000_0003, 1);
    exp4(1, 32'h4000_0004, 2);
    wait_writes(base + 2);
    bus4.fifo_full = 1'b1;
    for (int s = 0; s < 3; s++) begin
      #2;
      chk("stall fifo_wr_en", 64'(bus4.fifo_wr_en), 64'd0);
      chk("stall req_ready", 64'(bus4.req_ready), 64'd0);
      chk("stall grant held", 64'(bus4.grant_valid), 64'd1);
      @(negedge clk);
    end
    bus4.fifo_full = 1'b0;
    wait_drain(4);

    // Reset after two beats of requester 2; requester 0 then wins (rr_ptr back to 0).
    base = wr4;
    for (int k = 0; k < 4; k++) pq4[2].push_back(32'h5200_0000 + 32'(k));
    exp4(2, 32'h5200_0000, -1);
    exp4(2, 32'h5200_0001, 1);
    exp4(0, 32'h5000_00A0, 3);
    exp4(0, 32'h5000_00B0, 1);
    exp4(2, 32'h5200_0002, 3);
    exp4(2, 32'h5200_0003, 1);
    wait_writes(base + 2);
    rst = 1'b1;
    pq4[0].push_back(32'h5000_00A0);
    pq4[0].push_back(32'h5000_00B0);
    #2;
    chk("mid-burst reset fifo_wr_en", 64'(bus4.fifo_wr_en), 64'd0);
    chk("mid-burst reset fifo_cs", 64'(bus4.fifo_cs), 64'd0);
    chk("mid-burst reset req_ready", 64'(bus4.req_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_drain(4);

    // NUM_REQ=3 wrap: grant 1 moves rr_ptr to 2, then 2 before 0, then 1 before 2.
    pq3[1].push_back(32'h6100_0000);
    exp3(1, 32'h6100_0000, -1);
    wait_drain(3);
    pq3[2].push_back(32'h6200_0000);
    pq3[2].push_back(32'h6200_0001);
    pq3[0].push_back(32'h6000_0000);
    pq3[0].push_back(32'h6000_0001);
    exp3(2, 32'h6200_0000, -1);
    exp3(2, 32'h6200_0001, 1);
    exp3(0, 32'h6000_0000, 3);
    exp3(0, 32'h6000_0001, 1);
    wait_drain(3);
    pq3[2].push_back(32'h6200_0002);
    pq3[1].push_back(32'h6100_0001);
    exp3(1, 32'h6100_0001, -1);
    exp3(2, 32'h6200_0002, 3);
    wait_drain(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
